// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared defaults and types for the register scoreboard
// Purpose: default index width, zero-register index and register index/vector types.
// Ports: none (package).
package reg_scoreboard_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int NREG_DEF   = 2**ADDR_W_DEF;
  localparam int ZR_IDX_DEF = NREG_DEF - 1;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [NREG_DEF-1:0]   reg_vec_t;

endpackage

// File: rtl/reg_scoreboard_dec.sv
// rtl/reg_scoreboard_dec.sv - N-to-2^N one-hot decoder with enable
// Purpose: purely combinational one-hot decode of i_sel, all-zero when i_en is low.
// Ports:
//   i_en     - decode enable
//   i_sel    - N-bit index
//   o_onehot - 2^N-bit one-hot result
module dec_n_en #(
  parameter int N = 5
) (
  input  logic            i_en,
  input  logic [N-1:0]    i_sel,
  output logic [2**N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register pending-write scoreboard with hazard detection
// Purpose: tracks one pending bit per architectural register between issue and
// writeback, flags operand stalls and keeps a registered population count.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   set_en, set_addr    - issue of an instruction writing set_addr
//   clr_en, clr_addr    - writeback of clr_addr
//   rd_a, rd_b          - source operand indices
//   pending             - registered pending vector
//   hazard_a, hazard_b  - combinational stall flags per operand
//   count               - registered number of pending bits
//   full                - count equals NREG-1
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = 2**ADDR_W,
  parameter int ZR_IDX = NREG - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic [NREG-1:0]   pending,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  logic [2**ADDR_W-1:0] w_set_dec;
  logic [2**ADDR_W-1:0] w_clr_dec;
  logic [NREG-1:0]      w_mask;
  logic [NREG-1:0]      w_set;
  logic [NREG-1:0]      w_clr;
  logic [NREG-1:0]      w_next;
  logic                 w_inc;
  logic                 w_dec;
  logic [NREG-1:0]      r_pending;
  logic [ADDR_W:0]      r_count;

  dec_n_en #(.N(ADDR_W)) u_dec_set (
    .i_en     (set_en),
    .i_sel    (set_addr),
    .o_onehot (w_set_dec)
  );

  dec_n_en #(.N(ADDR_W)) u_dec_clr (
    .i_en     (clr_en),
    .i_sel    (clr_addr),
    .o_onehot (w_clr_dec)
  );

  // Zero register is never tracked; indices at or above NREG fall off the
  // top of the decoder output and are dropped by the truncation below.
  for (genvar g = 0; g < NREG; g++) begin : g_mask
    assign w_mask[g] = (g != ZR_IDX);
  end

  assign w_set  = w_set_dec[NREG-1:0] & w_mask;
  assign w_clr  = w_clr_dec[NREG-1:0] & w_mask;
  assign w_next = (r_pending & ~w_clr) | w_set;

  // Decoded vectors are one-hot, so at most one bit rises and one falls per cycle.
  // A set on an already-pending bit, or a clear overridden by set, is not a change.
  assign w_inc = |(w_set & ~r_pending);
  assign w_dec = |(w_clr & r_pending & ~w_set);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_next;
      r_count   <= r_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
    end
  end

  // Same-cycle writeback of the operand releases the stall; a same-cycle
  // issue only shows up once it is registered.
  function automatic logic hz(input logic [NREG-1:0]   pv,
                              input logic [ADDR_W-1:0] rd,
                              input logic              cen,
                              input logic [ADDR_W-1:0] caddr);
    hz = 1'b0;
    if ((32'(rd) < NREG) && (32'(rd) != ZR_IDX))
      hz = pv[rd] & ~(cen && (caddr == rd));
  endfunction

  // Reset gating keeps stale pre-reset state from stalling or reporting full.
  assign hazard_a = ~reset & hz(r_pending, rd_a, clr_en, clr_addr);
  assign hazard_b = ~reset & hz(r_pending, rd_b, clr_en, clr_addr);
  assign full     = ~reset & (r_count == (ADDR_W+1)'(NREG - 1));

  assign pending = r_pending;
  assign count   = r_count;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_en;
  reg_idx_t   set_addr;
  logic       clr_en;
  reg_idx_t   clr_addr;
  reg_idx_t   rd_a;
  reg_idx_t   rd_b;
  reg_vec_t   pending;
  logic       hazard_a;
  logic       hazard_b;
  logic [5:0] count;
  logic       full;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  reg_vec_t m_pend = '0;

  reg_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (set_addr),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .pending  (pending),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b),
    .count    (count),
    .full     (full)
  );

  always #5 clk = ~clk;

  // Model: a set of outstanding destination registers.
  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0;
    end else begin
      if (clr_en && clr_addr != 5'd31) m_pend[clr_addr] = 1'b0;
      if (set_en && set_addr != 5'd31) m_pend[set_addr] = 1'b1;
    end
  end

  function automatic logic exp_hz(input reg_idx_t rd);
    if (reset || rd == 5'd31) return 1'b0;
    return m_pend[rd] && !(clr_en && clr_addr == rd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_pending", pending, m_pend);
      chk("cyc_count", 32'(count), $countones(m_pend));
      chk("cyc_full", 32'(full), 32'(!reset && $countones(m_pend) == 31));
      chk("cyc_hazard_a", 32'(hazard_a), 32'(exp_hz(rd_a)));
      chk("cyc_hazard_b", 32'(hazard_b), 32'(exp_hz(rd_b)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_en = 0; clr_en = 0; reset = 0;
  endtask

  initial begin
    reset = 1; set_en = 0; set_addr = '0; clr_en = 0; clr_addr = '0; rd_a = '0; rd_b = '0;
    tick();
    check_en = 1'b1;
    tick();
    reset = 0;
    chk("reset_pending", pending, 32'h0);
    chk("reset_count", 32'(count), 32'd0);

    // Single issue then operand stall
    set_en = 1; set_addr = 5'd3;
    tick();
    idle(); rd_a = 5'd3;
    #1;
    chk("set3_pending", pending, 32'h0000_0008);
    chk("set3_count", 32'(count), 32'd1);
    chk("set3_hazard_a", 32'(hazard_a), 32'd1);

    // Writeback bypass
    clr_en = 1; clr_addr = 5'd3;
    #1;
    chk("bypass_hazard_a", 32'(hazard_a), 32'd0);
    tick();
    idle();
    chk("clr3_bit", 32'(pending[3]), 32'd0);
    chk("clr3_count", 32'(count), 32'd0);

    // Clear of a non-pending bit
    clr_en = 1; clr_addr = 5'd9;
    tick();
    idle();
    chk("noop_clr_count", 32'(count), 32'd0);

    // Set and clear together: set wins
    set_en = 1; set_addr = 5'd3;
    tick();
    set_en = 1; set_addr = 5'd3; clr_en = 1; clr_addr = 5'd3;
    tick();
    idle();
    chk("setclr_bit", 32'(pending[3]), 32'd1);
    chk("setclr_count", 32'(count), 32'd1);
    clr_en = 1; clr_addr = 5'd3;
    tick();
    idle();

    // Zero register
    set_en = 1; set_addr = 5'd31;
    tick();
    idle(); rd_b = 5'd31;
    #1;
    chk("zr_pending", pending, 32'h0);
    chk("zr_count", 32'(count), 32'd0);
    chk("zr_hazard_b", 32'(hazard_b), 32'd0);

    // Fill to full
    for (int i = 0; i < 31; i++) begin
      set_en = 1; set_addr = reg_idx_t'(i);
      tick();
    end
    idle(); rd_b = 5'd30;
    #1;
    chk("fill_pending", pending, 32'h7FFF_FFFF);
    chk("fill_count", 32'(count), 32'd31);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_hazard_b", 32'(hazard_b), 32'd1);
    set_en = 1; set_addr = 5'd5;
    tick();
    idle();
    chk("reset5_count", 32'(count), 32'd31);

    // Mixed traffic for the per-cycle comparison
    for (int i = 0; i < 200; i++) begin
      set_en   = ($urandom_range(0, 1) == 1);
      set_addr = reg_idx_t'($urandom_range(0, 31));
      clr_en   = ($urandom_range(0, 2) != 0);
      clr_addr = reg_idx_t'($urandom_range(0, 31));
      rd_a     = reg_idx_t'($urandom_range(0, 31));
      rd_b     = clr_addr;
      tick();
    end
    idle();

    // Reset mid-operation with a concurrent set
    reset = 1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      set_en = 1; set_addr = reg_idx_t'(i);
      tick();
    end
    idle(); rd_a = 5'd2;
    #1;
    chk("ten_count", 32'(count), 32'd10);
    reset = 1; set_en = 1; set_addr = 5'd7;
    #1;
    chk("rst_cycle_hazard_a", 32'(hazard_a), 32'd0);
    chk("rst_cycle_full", 32'(full), 32'd0);
    tick();
    idle();
    chk("rst_pending", pending, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_next_hazard_a", 32'(hazard_a), 32'd0);
    tick();
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-index width.
REQ-002 Parameter NREG, default 2**ADDR_W, tracked register count.
REQ-003 Parameter ZR_IDX, default NREG-1, hardwired zero register that is never tracked.
REQ-004 clk  input  1  sole clock, all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 set_en  input  1  issue of an instruction that writes register set_addr.
REQ-007 set_addr  input  ADDR_W  destination index decoded for set.
REQ-008 clr_en  input  1  writeback of register clr_addr.
REQ-009 clr_addr  input  ADDR_W  destination index decoded for clear.
REQ-010 rd_a  input  ADDR_W  source operand A index.
REQ-011 rd_b  input  ADDR_W  source operand B index.
REQ-012 pending  output  NREG  registered pending bit per register.
REQ-013 hazard_a  output  1  operand A must stall.
REQ-014 hazard_b  output  1  operand B must stall.
REQ-015 count  output  ADDR_W+1  registered number of set pending bits.
REQ-016 full  output  1  count equals NREG-1.

Function
REQ-017 set_addr SHALL be decoded one-hot gated by set_en, and clr_addr one-hot gated by clr_en, each through an N-to-2^N enabled decoder.
REQ-018 Next pending SHALL be (pending & ~clr_onehot) | set_onehot, registered on the next edge (latency 1).
REQ-019 Simultaneous set and clear of the same index SHALL leave the bit set (set wins).
REQ-020 Set of an already-pending bit SHALL leave it set and SHALL NOT change count.
REQ-021 Clear of a non-pending bit SHALL be a no-op.
REQ-022 Bit ZR_IDX SHALL always read 0; set or clear at ZR_IDX is ignored.
REQ-023 set_addr or clr_addr >= NREG SHALL be ignored.
REQ-024 count SHALL be registered and SHALL equal popcount(pending) every cycle, with +1/-1/0 update rules consistent with REQ-019 to REQ-023.
REQ-025 hazard_x SHALL be combinational: pending[rd_x] & ~(clr_en & clr_addr==rd_x & pending[rd_x]), i.e. a same-cycle writeback bypasses the stall.
REQ-026 hazard_x SHALL NOT reflect a same-cycle set; a set affects hazards from the next cycle.
REQ-027 hazard_x SHALL be 0 when rd_x equals ZR_IDX or rd_x >= NREG.
REQ-028 full SHALL be derived from registered count only.

Reset
REQ-029 When reset is high at a rising edge, pending SHALL become all-zero and count zero, overriding any same-cycle set or clear.
REQ-030 During the reset cycle and the following cycle, hazard_a, hazard_b and full SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding pending bits, with no partial state retained.

Structure
REQ-032 The shared package SHALL hold the ADDR_W default, the ZR_IDX default, and typedefs reg_idx_t (ADDR_W bits) and reg_vec_t (NREG bits).
REQ-033 One sub-module, dec_n_en (parametrised N-to-2^N decoder with enable), SHALL be instantiated twice, for set and for clear.
REQ-034 The decoder SHALL be purely combinational; all state SHALL reside in reg_scoreboard.

Verification
REQ-035 Reset, then set_en=1 set_addr=3 for one cycle -> next cycle pending=0x00000008, count=1; rd_a=3 -> hazard_a=1.
REQ-036 With reg 3 pending, clr_en=1 clr_addr=3 and rd_a=3 in the same cycle -> hazard_a=0 that cycle; next cycle pending[3]=0, count=0.
REQ-037 With reg 3 pending, set and clear of 3 in the same cycle -> pending[3] stays 1 and count stays 1.
REQ-038 set_addr=31 -> pending=0, count=0; rd_b=31 -> hazard_b=0.
REQ-039 Set indices 0..30 on consecutive cycles -> count=31 and full=1; a repeat set of 5 -> count unchanged.
REQ-040 With 10 bits pending, reset for one cycle while set_addr=7 is applied -> pending=0, count=0, full=0.
